// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the forward decoder and the scan-readback decoder.
// Segment bit order is a..g from seg[6] down to seg[0], all active-high.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_ILLEGAL = 4'hE;

    // Forward mapping; anything that is not a decimal digit shows as blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] pattern;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational reverse decoder: one 7-segment pattern to its BCD code.
// Blank decodes to BCD_BLANK; any unrecognised pattern gives BCD_ILLEGAL plus the illegal flag.
module seg7_to_bcd (
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       illegal
);
    import seg7_pkg::*;

    always_comb begin
        code    = BCD_ILLEGAL;
        illegal = 1'b1;
        case (seg)
            SEG_0:     begin code = 4'd0;      illegal = 1'b0; end
            SEG_1:     begin code = 4'd1;      illegal = 1'b0; end
            SEG_2:     begin code = 4'd2;      illegal = 1'b0; end
            SEG_3:     begin code = 4'd3;      illegal = 1'b0; end
            SEG_4:     begin code = 4'd4;      illegal = 1'b0; end
            SEG_5:     begin code = 4'd5;      illegal = 1'b0; end
            SEG_6:     begin code = 4'd6;      illegal = 1'b0; end
            SEG_7:     begin code = 4'd7;      illegal = 1'b0; end
            SEG_8:     begin code = 4'd8;      illegal = 1'b0; end
            SEG_9:     begin code = 4'd9;      illegal = 1'b0; end
            SEG_BLANK: begin code = BCD_BLANK; illegal = 1'b0; end
            default:   begin code = BCD_ILLEGAL; illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Rebuilds the multi-digit BCD value shown on a scanned 7-segment bus.
// Digits are captured once stable, assembled into frames, and offered on a valid/ready output.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    frame_err,
    output logic                    overrun
);
    import seg7_pkg::*;

    localparam int CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam int SAMPLE_W = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

    logic [SAMPLE_W-1:0]   prev_sample;
    logic [CNT_W-1:0]      stable_cnt;
    logic [NUM_DIGITS-1:0] seen;
    logic                  err_acc;
    logic [3:0]            slot [NUM_DIGITS];

    logic [3:0] code;
    logic       illegal;
    logic       onehot;
    logic       same;
    logic       capture;
    logic       complete;
    logic       load;

    seg7_to_bcd u_dec (
        .seg     (seg),
        .code    (code),
        .illegal (illegal)
    );

    assign onehot   = $onehot(an);
    assign same     = ({an, seg} == prev_sample);
    assign capture  = onehot && same && (stable_cnt == CNT_CAP);
    assign complete = &seen;
    assign load     = complete && (!out_valid || out_ready);

    // Saturating at CNT_MAX (one past the capture value) is what stops a held digit re-capturing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_sample <= '0;
            stable_cnt  <= '0;
        end else begin
            prev_sample <= {an, seg};
            if (onehot && same) begin
                stable_cnt <= (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 1'b1;
            end else begin
                stable_cnt <= onehot ? CNT_W'(1) : '0;
            end
        end
    end

    // A capture in the completion cycle belongs to the next frame, so it survives the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen    <= '0;
            err_acc <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot[i] <= '0;
            end
        end else begin
            seen    <= (complete ? '0 : seen) | (capture ? an : '0);
            err_acc <= (complete ? 1'b0 : err_acc) | (capture && illegal);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && an[i]) begin
                    slot[i] <= code;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_out   <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= complete && !load;
            if (load) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    bcd_out[4*i +: 4] <= slot[i];
                end
                frame_err <= err_acc;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
